// File: rtl/pm_arb_pkg.sv
// Shared definitions for the program-memory arbiter: FSM state encoding,
// read-owner tags and the starvation counter width.
package pm_arb_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STEAL = 2'd1,
    HALT  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_LD  = 1'b1
  } owner_t;

  localparam int WAIT_W = 4;

endpackage

// File: rtl/pm_arb_wait_cnt.sv
// Saturating starvation counter for a pending loader request. Clear has
// priority over increment; term flags the cycle the count equals LIMIT.
module pm_arb_wait_cnt
  import pm_arb_pkg::*;
#(
  parameter int LIMIT = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic term
);

  logic [WAIT_W-1:0] cnt;

  // Count unserved loader cycles, holding at all-ones.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign term = (cnt == LIMIT[WAIT_W-1:0]);

endmodule

// File: rtl/pm_arbiter.sv
// Program-memory arbiter: shares the single-port program SRAM between the
// CPU (fetch/LPM/SPM) and a loader/debug port. CPU has priority; the loader
// takes idle slots, steals one cycle after MAX_WAIT unserved cycles, or
// halts the CPU for bulk programming.
// Optional build macro PM_ARB_WPROT_EN: suppresses writes below BOOT_WORDS
// and reports them on the sticky wp_err output.
module pm_arbiter
  import pm_arb_pkg::*;
#(
  parameter int MAX_WAIT = 4
`ifdef PM_ARB_WPROT_EN
  , parameter logic [15:0] BOOT_WORDS = 16'h0200
`endif
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] cpu_pm_addr,
  input  logic        cpu_pm_re,
  input  logic        cpu_pm_we,
  input  logic [15:0] cpu_pm_wdata,
  output logic [15:0] cpu_pm_rdata,
  output logic        cpu_hold,
  input  logic        ld_req,
  input  logic        ld_we,
  input  logic [15:0] ld_addr,
  input  logic [15:0] ld_wdata,
  input  logic        ld_halt,
  output logic        ld_gnt,
  output logic        ld_rvalid,
  output logic [15:0] ld_rdata,
  output logic        ld_halted,
  output logic [15:0] sram_addr,
  output logic        sram_re,
  output logic        sram_we,
  output logic [15:0] sram_wdata,
  input  logic [15:0] sram_rdata
`ifdef PM_ARB_WPROT_EN
  , output logic      wp_err
`endif
);

  state_t      state, state_nxt;
  owner_t      rd_owner;
  logic        rd_pend;
  logic [15:0] cpu_rdata_q;

  logic cpu_req, ld_sel, cpu_sel, wait_term, steal_due, wait_clr, wait_inc;
  logic we_raw, cpu_rd_ret;

  assign cpu_req = cpu_pm_re | cpu_pm_we;

  // Select who owns the SRAM port this cycle.
  always_comb begin
    ld_sel  = 1'b0;
    cpu_sel = 1'b0;
    if (state == RUN) begin
      ld_sel  = ld_req & ~cpu_req;
      cpu_sel = cpu_req;
    end else begin
      ld_sel  = ld_req;
    end
  end

  assign ld_gnt    = ld_sel;
  assign wait_clr  = (state != RUN) | ~ld_req | ld_sel;
  assign wait_inc  = ld_req & ~ld_sel;
  assign steal_due = (state == RUN) & ld_req & ~ld_sel & wait_term;

  pm_arb_wait_cnt #(
    .LIMIT(MAX_WAIT - 1)
  ) u_wait_cnt (
    .clock(clock),
    .reset(reset),
    .clr  (wait_clr),
    .inc  (wait_inc),
    .term (wait_term)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  // Next-state decode; a halt request outranks a due steal.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (ld_halt)        state_nxt = HALT;
        else if (steal_due) state_nxt = STEAL;
      end
      STEAL:   state_nxt = ld_halt ? HALT : RUN;
      HALT:    state_nxt = ld_halt ? HALT : RUN;
      default: state_nxt = RUN;
    endcase
  end

  // Hold and halt indications come straight from the state register.
  assign cpu_hold  = (state != RUN);
  assign ld_halted = (state == HALT);

  // SRAM port mux; write beats read for a CPU that asserts both.
  always_comb begin
    sram_addr  = '0;
    sram_wdata = '0;
    sram_re    = 1'b0;
    we_raw     = 1'b0;
    if (ld_sel) begin
      sram_addr  = ld_addr;
      sram_wdata = ld_wdata;
      sram_re    = ~ld_we;
      we_raw     = ld_we;
    end else if (cpu_sel) begin
      sram_addr  = cpu_pm_addr;
      sram_wdata = cpu_pm_wdata;
      sram_re    = cpu_pm_re & ~cpu_pm_we;
      we_raw     = cpu_pm_we;
    end
  end

`ifdef PM_ARB_WPROT_EN
  logic wp_block;
  assign wp_block = we_raw & (sram_addr < BOOT_WORDS);
  assign sram_we  = we_raw & ~wp_block;

  // Sticky record of any write aimed at the boot region.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)         wp_err <= 1'b0;
    else if (wp_block) wp_err <= 1'b1;
  end
`else
  assign sram_we = we_raw;
`endif

  // Track who issued last cycle's read so the returning data is steered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_pend     <= 1'b0;
      rd_owner    <= OWN_CPU;
      cpu_rdata_q <= '0;
    end else begin
      rd_pend  <= sram_re;
      rd_owner <= ld_sel ? OWN_LD : OWN_CPU;
      if (cpu_rd_ret) cpu_rdata_q <= sram_rdata;
    end
  end

  assign cpu_rd_ret   = rd_pend & (rd_owner == OWN_CPU);
  assign cpu_pm_rdata = cpu_rd_ret ? sram_rdata : cpu_rdata_q;
  assign ld_rvalid    = rd_pend & (rd_owner == OWN_LD);
  assign ld_rdata     = sram_rdata;

endmodule

// File: tb/tb_pm_arbiter.sv
// Bench for pm_arbiter: behavioural SRAM, table of single-cycle RUN-state
// vectors, hand-written steal/halt/reset sequences and a read-data queue.
module tb_pm_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] cpu_pm_addr, cpu_pm_wdata, ld_addr, ld_wdata;
  logic        cpu_pm_re, cpu_pm_we, ld_req, ld_we, ld_halt;
  logic [15:0] cpu_pm_rdata, ld_rdata, sram_addr, sram_wdata;
  logic [15:0] sram_rdata = 16'h0;
  logic        cpu_hold, ld_gnt, ld_rvalid, ld_halted, sram_re, sram_we;
`ifdef PM_ARB_WPROT_EN
  logic        wp_err;
`endif

  int checks = 0;
  int errors = 0;
  logic [15:0] sb[$];

  pm_arbiter #(.MAX_WAIT(4)) dut (
    .clock(clock), .reset(reset),
    .cpu_pm_addr(cpu_pm_addr), .cpu_pm_re(cpu_pm_re), .cpu_pm_we(cpu_pm_we),
    .cpu_pm_wdata(cpu_pm_wdata), .cpu_pm_rdata(cpu_pm_rdata), .cpu_hold(cpu_hold),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_halt(ld_halt), .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .ld_halted(ld_halted), .sram_addr(sram_addr), .sram_re(sram_re),
    .sram_we(sram_we), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
`ifdef PM_ARB_WPROT_EN
    , .wp_err(wp_err)
`endif
  );

  always #5 clock = ~clock;

  // Unwritten locations read back as a fixed pattern of their address.
  function automatic logic [15:0] pat(input logic [15:0] a);
    return a ^ 16'h5A3C;
  endfunction

  bit [15:0] mem [65536];
  bit        written [65536];

  // Single-port SRAM, one-cycle read latency.
  always @(posedge clock) begin
    if (sram_we) begin
      mem[sram_addr]     <= sram_wdata;
      written[sram_addr] <= 1'b1;
    end
    if (sram_re) sram_rdata <= written[sram_addr] ? mem[sram_addr] : pat(sram_addr);
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Loader read data is compared against the queue when it comes back.
  always @(negedge clock) begin
    if (!reset && ld_rvalid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ld_rvalid_unexpected: got 1 expected 0");
      end else begin
        chk("ld_rdata", {16'h0, ld_rdata}, {16'h0, sb.pop_front()});
      end
    end
  end

  typedef struct {
    logic        cre, cwe;
    logic [15:0] caddr, cwd;
    logic        lreq, lwe;
    logic [15:0] laddr, lwd;
    logic        e_gnt, e_re, e_we;
    logic [15:0] e_addr, e_wd;
  } vec_t;

  vec_t vecs [7];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    cpu_pm_re = 0; cpu_pm_we = 0; cpu_pm_addr = 0; cpu_pm_wdata = 0;
    ld_req = 0; ld_we = 0; ld_addr = 0; ld_wdata = 0; ld_halt = 0;
  endtask

  int grants;

  initial begin
    reset = 1'b1;
    idle();

    // Reset state: loader idle-slot grant is already live.
    ld_req = 1; ld_addr = 16'h0040;
    #3;
    chk("rst_hold", {31'h0, cpu_hold}, 0);
    chk("rst_halted", {31'h0, ld_halted}, 0);
    chk("rst_rvalid", {31'h0, ld_rvalid}, 0);
    chk("rst_cpu_rdata", {16'h0, cpu_pm_rdata}, 0);
    chk("rst_gnt", {31'h0, ld_gnt}, 1);
    idle();
    tick();
    reset = 1'b0;

    //            cre cwe caddr     cwd       lreq lwe laddr     lwd       gnt re we addr      wd
    vecs[0] = '{1'b0,1'b0,16'h0000,16'h0000,1'b1,1'b1,16'h0300,16'hBEEF,1'b1,1'b0,1'b1,16'h0300,16'hBEEF};
    vecs[1] = '{1'b1,1'b0,16'h0010,16'h0000,1'b0,1'b0,16'h0000,16'h0000,1'b0,1'b1,1'b0,16'h0010,16'h0000};
    vecs[2] = '{1'b0,1'b1,16'h0250,16'h1234,1'b0,1'b0,16'h0000,16'h0000,1'b0,1'b0,1'b1,16'h0250,16'h1234};
    vecs[3] = '{1'b1,1'b1,16'h0260,16'h5555,1'b0,1'b0,16'h0000,16'h0000,1'b0,1'b0,1'b1,16'h0260,16'h5555};
    vecs[4] = '{1'b1,1'b0,16'h0020,16'h0000,1'b1,1'b0,16'h0030,16'h0000,1'b0,1'b1,1'b0,16'h0020,16'h0000};
    vecs[5] = '{1'b0,1'b0,16'h0000,16'h0000,1'b1,1'b0,16'h0040,16'h0000,1'b1,1'b1,1'b0,16'h0040,16'h0000};
    vecs[6] = '{1'b0,1'b0,16'h0000,16'h0000,1'b0,1'b0,16'h0000,16'h0000,1'b0,1'b0,1'b0,16'h0000,16'h0000};

    for (int i = 0; i < 7; i++) begin
      tick();
      cpu_pm_re = vecs[i].cre; cpu_pm_we = vecs[i].cwe;
      cpu_pm_addr = vecs[i].caddr; cpu_pm_wdata = vecs[i].cwd;
      ld_req = vecs[i].lreq; ld_we = vecs[i].lwe;
      ld_addr = vecs[i].laddr; ld_wdata = vecs[i].lwd;
      if (vecs[i].e_gnt && !vecs[i].lwe) sb.push_back(pat(vecs[i].laddr));
      #3;
      chk($sformatf("vec%0d_gnt", i), {31'h0, ld_gnt}, {31'h0, vecs[i].e_gnt});
      chk($sformatf("vec%0d_re", i), {31'h0, sram_re}, {31'h0, vecs[i].e_re});
      chk($sformatf("vec%0d_we", i), {31'h0, sram_we}, {31'h0, vecs[i].e_we});
      chk($sformatf("vec%0d_addr", i), {16'h0, sram_addr}, {16'h0, vecs[i].e_addr});
      chk($sformatf("vec%0d_wdata", i), {16'h0, sram_wdata}, {16'h0, vecs[i].e_wd});
      chk($sformatf("vec%0d_hold", i), {31'h0, cpu_hold}, 0);
      tick();
      idle();
    end

    // Starved loader read: four unserved cycles, then a one-cycle steal.
    for (int c = 0; c < 6; c++) begin
      tick();
      cpu_pm_re = 1; cpu_pm_addr = 16'h0005;
      ld_req = (c < 5); ld_we = 0; ld_addr = 16'h0010;
      if (c == 4) sb.push_back(pat(16'h0010));
      #3;
      if (c < 4) begin
        chk($sformatf("steal_wait%0d_hold", c), {31'h0, cpu_hold}, 0);
        chk($sformatf("steal_wait%0d_gnt", c), {31'h0, ld_gnt}, 0);
        chk($sformatf("steal_wait%0d_addr", c), {16'h0, sram_addr}, 32'h0005);
      end else if (c == 4) begin
        chk("steal_hold", {31'h0, cpu_hold}, 1);
        chk("steal_gnt", {31'h0, ld_gnt}, 1);
        chk("steal_addr", {16'h0, sram_addr}, 32'h0010);
        chk("steal_re", {31'h0, sram_re}, 1);
        chk("steal_cpu_rdata", {16'h0, cpu_pm_rdata}, {16'h0, pat(16'h0005)});
      end else begin
        chk("post_steal_hold", {31'h0, cpu_hold}, 0);
        chk("post_steal_rvalid", {31'h0, ld_rvalid}, 1);
        chk("post_steal_cpu_rdata", {16'h0, cpu_pm_rdata}, {16'h0, pat(16'h0005)});
      end
    end
    tick();
    idle();

    // Halt for bulk writes while the CPU holds a fetch.
    tick();
    cpu_pm_re = 1; cpu_pm_addr = 16'h0077; ld_halt = 1;
    #3;
    chk("halt_entry_hold", {31'h0, cpu_hold}, 0);
    grants = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      ld_halt = (i < 10);
      ld_req = 1; ld_we = 1;
      ld_addr = 16'h0400 + 16'(i); ld_wdata = 16'hC000 + 16'(i);
      #3;
      chk($sformatf("halt%0d_hold", i), {31'h0, cpu_hold}, 1);
      chk($sformatf("halt%0d_halted", i), {31'h0, ld_halted}, 1);
      chk($sformatf("halt%0d_we", i), {31'h0, sram_we}, 1);
      chk($sformatf("halt%0d_addr", i), {16'h0, sram_addr}, 32'h0400 + i);
      if (ld_gnt) grants++;
    end
    chk("halt_grants", grants, 10);
    tick();
    ld_req = 0; ld_we = 0; ld_halt = 0;
    #3;
    chk("halt_exit_hold", {31'h0, cpu_hold}, 0);
    chk("halt_exit_halted", {31'h0, ld_halted}, 0);
    chk("halt_exit_refetch_re", {31'h0, sram_re}, 1);
    chk("halt_exit_refetch_addr", {16'h0, sram_addr}, 32'h0077);
    tick();
    cpu_pm_re = 0; ld_req = 1; ld_we = 0; ld_addr = 16'h0403;
    sb.push_back(16'hC003);
    #3;
    chk("refetch_cpu_rdata", {16'h0, cpu_pm_rdata}, {16'h0, pat(16'h0077)});
    chk("readback_gnt", {31'h0, ld_gnt}, 1);
    tick();
    idle();

    // Reset pulse in the middle of a halt.
    tick();
    ld_halt = 1; cpu_pm_re = 1; cpu_pm_addr = 16'h0000;
    tick();
    #3;
    chk("pre_reset_hold", {31'h0, cpu_hold}, 1);
    #1 reset = 1'b1;
    #1;
    chk("async_reset_hold", {31'h0, cpu_hold}, 0);
    chk("async_reset_halted", {31'h0, ld_halted}, 0);
    ld_halt = 0;
    tick();
    reset = 1'b0;
    #3;
    chk("post_reset_hold", {31'h0, cpu_hold}, 0);
    chk("post_reset_re", {31'h0, sram_re}, 1);
    chk("post_reset_addr", {16'h0, sram_addr}, 32'h0000);
    tick();
    cpu_pm_re = 0;
    #3;
    chk("post_reset_cpu_rdata", {16'h0, cpu_pm_rdata}, {16'h0, pat(16'h0000)});

`ifdef PM_ARB_WPROT_EN
    // Boot-region writes are dropped and flagged; the boundary passes.
    tick();
    cpu_pm_we = 1; cpu_pm_addr = 16'h0100; cpu_pm_wdata = 16'h1111;
    #3;
    chk("wp_block_we", {31'h0, sram_we}, 0);
    tick();
    cpu_pm_we = 0;
    #3;
    chk("wp_err_set", {31'h0, wp_err}, 1);
    tick();
    cpu_pm_we = 1; cpu_pm_addr = 16'h0200;
    #3;
    chk("wp_boundary_we", {31'h0, sram_we}, 1);
    tick();
    cpu_pm_we = 0;
    #3;
    chk("wp_err_sticky", {31'h0, wp_err}, 1);
`endif

    tick();
    idle();
    tick();
    tick();
    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
